dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Single-port data memory responder for an RV32I load/store unit.
//             Accepts one request at a time over a valid/ready handshake,
//             inserts WAIT wait-state cycles, then performs the access and
//             holds the response until the initiator takes it.
//  Ports    : clk, reset (async, active-low)
//             req_valid/req_ready   request handshake
//             req_we, req_funct3    store/load flag and RV32I width code
//             req_addr, req_wdata   byte address, right-aligned store data
//             rsp_valid/rsp_ready   response handshake
//             rsp_rdata, rsp_err    extended load data, reject flag
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] c_depth     = 30'(DEPTH);
    localparam bit          c_no_wait   = (WAIT == 0);
    localparam logic [3:0]  c_wait_init = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_wait = 2'd1;
    localparam logic [1:0]  c_st_resp = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic             r_ready;
    logic             r_valid;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [31:0]      r_mem [DEPTH];

    logic             w_accept;
    logic             w_go_resp;
    logic             w_we;
    logic [2:0]       w_funct3;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [c_aw-1:0]  w_idx;
    logic [31:0]      w_word;
    logic [31:0]      w_shift;
    logic [31:0]      w_wshift;
    logic [31:0]      w_load;
    logic [3:0]       w_be;
    logic             w_err;
    logic [31:0]      w_merged;
    logic [31:0]      w_rsp_data;
    logic             w_wr;

    assign req_ready = r_ready;
    assign rsp_valid = r_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept  = req_valid & r_ready;

    // With no wait states the access happens on the acceptance edge itself,
    // so the request fields come straight from the ports; otherwise they come
    // from the copy latched at acceptance.
    assign w_go_resp = ((r_state == c_st_idle) & w_accept & c_no_wait) |
                       ((r_state == c_st_wait) & (r_cnt == 4'd0));
    assign w_we      = (r_state == c_st_idle) ? req_we     : r_we;
    assign w_funct3  = (r_state == c_st_idle) ? req_funct3 : r_funct3;
    assign w_addr    = (r_state == c_st_idle) ? req_addr   : r_addr;
    assign w_wdata   = (r_state == c_st_idle) ? req_wdata  : r_wdata;

    assign w_idx     = w_addr[c_aw+1:2];
    assign w_word    = r_mem[w_idx];
    assign w_shift   = w_word >> {w_addr[1:0], 3'b000};
    assign w_wshift  = w_wdata << {w_addr[1:0], 3'b000};

    always_comb begin
        w_load = 32'd0;
        w_be   = 4'b0000;
        w_err  = 1'b0;
        case (w_funct3)
            3'b000: begin
                w_load = {{24{w_shift[7]}}, w_shift[7:0]};
                w_be   = 4'b0001 << w_addr[1:0];
            end
            3'b001: begin
                w_load = {{16{w_shift[15]}}, w_shift[15:0]};
                w_be   = 4'b0011 << {w_addr[1], 1'b0};
                w_err  = w_addr[0];
            end
            3'b010: begin
                w_load = w_shift;
                w_be   = 4'b1111;
                w_err  = (w_addr[1:0] != 2'b00);
            end
            3'b100: begin
                w_load = {24'd0, w_shift[7:0]};
                w_be   = 4'b0001 << w_addr[1:0];
                w_err  = w_we;
            end
            3'b101: begin
                w_load = {16'd0, w_shift[15:0]};
                w_be   = 4'b0011 << {w_addr[1], 1'b0};
                w_err  = w_we | w_addr[0];
            end
            default: w_err = 1'b1;
        endcase
        if (w_addr[31:2] >= c_depth) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_wshift[8*i +: 8];
            end
        end
    end

    assign w_rsp_data = (w_we | w_err) ? 32'd0 : w_load;
    assign w_wr       = w_go_resp & w_we & ~w_err;

    // Memory has no reset: contents survive reset by design.  A store that is
    // still waiting when reset hits never reaches w_go_resp, so it is dropped.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_st_idle;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (c_no_wait) begin
                            r_state <= c_st_resp;
                            r_valid <= 1'b1;
                            r_rdata <= w_rsp_data;
                            r_err   <= w_err;
                        end else begin
                            r_state <= c_st_wait;
                            r_cnt   <= c_wait_init;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_st_resp;
                        r_valid <= 1'b1;
                        r_rdata <= w_rsp_data;
                        r_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_resp: begin
                    // Ready rises only after the completion edge, so a new
                    // request cannot overlap the outgoing response.
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (WAIT=2, DEPTH=256).
//             Directed steps followed by random loads/stores compared against
//             a byte-level memory model.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int WAITP  = 2;
    localparam int DEPTHP = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] m [DEPTHP];

    dmem_responder #(.DEPTH(DEPTHP), .WAIT(WAITP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: RV32I load/store semantics on a word array.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int          size;
        bit          sgn;
        int          off;
        int          idx;
        logic [31:0] mask;
        logic [31:0] val;
        size = 0;
        sgn  = 0;
        rd   = 32'd0;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        er = (size == 0);
        if (!er) er = ((a % size) != 0);
        if (we && (f3 == 3'd4 || f3 == 3'd5)) er = 1'b1;
        if ((a >> 2) >= DEPTHP) er = 1'b1;
        if (er) return;
        off  = int'(a % 4);
        idx  = int'(a >> 2);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (we) begin
            for (int b = 0; b < size; b++)
                m[idx][8*(off+b) +: 8] = wd[8*b +: 8];
        end else begin
            val = (m[idx] >> (8 * off)) & mask;
            if (sgn && val[8*size-1]) val = val | ~mask;
            rd = val;
        end
    endfunction

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          cyc;
        model(we, f3, a, wd, exp_rd, exp_er);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_timeout", 32'(cyc < 20), 32'd1);
        @(negedge clk);
        // Scramble the request bus: the DUT must work from its latched copy.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(WAITP + 1));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", 32'(rsp_err), 32'(exp_er));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rd = rsp_rdata;
        er = rsp_err;
        chk("rdata", rd, exp_rd);
        chk("err", 32'(er), 32'(exp_er));
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("valid_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra;

        // Reset state
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Store / load word round trip
        op(1'b1, 3'b010, 32'h64, 32'h19, 0, rd, er);
        chk("st64_rdata", rd, 32'd0);
        op(1'b0, 3'b010, 32'h64, 32'h0, 0, rd, er);
        chk("ld64", rd, 32'h19);
        chk("ld64_err", 32'(er), 32'd0);

        // Byte lane merge and extension
        op(1'b1, 3'b010, 32'h60, 32'h1122_3344, 0, rd, er);
        op(1'b1, 3'b000, 32'h61, 32'hAB, 0, rd, er);
        op(1'b0, 3'b010, 32'h60, 32'h0, 0, rd, er);
        chk("ld60_merge", rd, 32'h1122_AB44);
        op(1'b0, 3'b000, 32'h61, 32'h0, 0, rd, er);
        chk("lb61", rd, 32'hFFFF_FFAB);
        op(1'b0, 3'b100, 32'h61, 32'h0, 0, rd, er);
        chk("lbu61", rd, 32'h0000_00AB);

        // Misaligned / illegal / out of range
        op(1'b0, 3'b010, 32'h62, 32'h0, 0, rd, er);
        chk("lw62_err", 32'(er), 32'd1);
        chk("lw62_rdata", rd, 32'd0);
        op(1'b1, 3'b001, 32'h63, 32'hBEEF, 0, rd, er);
        chk("sh63_err", 32'(er), 32'd1);
        op(1'b0, 3'b010, 32'h60, 32'h0, 0, rd, er);
        chk("ld60_after_sh63", rd, 32'h1122_AB44);
        op(1'b0, 3'b010, 32'h400, 32'h0, 0, rd, er);
        chk("ld400_err", 32'(er), 32'd1);
        op(1'b1, 3'b101, 32'h60, 32'h5555, 0, rd, er);
        chk("st_f3_101_err", 32'(er), 32'd1);
        op(1'b0, 3'b010, 32'h60, 32'h0, 0, rd, er);
        chk("ld60_unchanged", rd, 32'h1122_AB44);

        // Backpressure in RESP
        op(1'b0, 3'b010, 32'h64, 32'h0, 5, rd, er);
        chk("ld64_hold", rd, 32'h19);

        // Reset during a waiting store discards it
        op(1'b1, 3'b010, 32'h70, 32'h5, 0, rd, er);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h70;
        req_wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rstwait_valid", 32'(rsp_valid), 32'd0);
        chk("rstwait_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstwait_valid_hold", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rstwait_ready_back", 32'(req_ready), 32'd1);
        op(1'b0, 3'b010, 32'h70, 32'h0, 0, rd, er);
        chk("ld70_kept", rd, 32'h5);

        // Random traffic in a fully initialised region
        for (int i = 0; i < 16; i++)
            op(1'b1, 3'b010, 32'h80 + 32'(4 * i), $urandom, 0, rd, er);
        for (int i = 0; i < 60; i++) begin
            rwe = 1'($urandom);
            rf3 = 3'($urandom);
            if ($urandom_range(0, 7) == 0)
                ra = 32'h400 + 32'($urandom_range(0, 255));
            else
                ra = 32'h80 + 32'($urandom_range(0, 63));
            op(rwe, rf3, ra, $urandom, int'($urandom_range(0, 2)), rd, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
